// File: rtl/vga_fb_mem.sv
// Double-buffered VGA frame-buffer memory: byte-enabled core port on the back page,
// read-only display port on the front page, vsync-aligned page swap and a back-page clear engine.
module vga_fb_mem #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 9600,
  parameter int NUM_PAGES = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [AW-1:0]     core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [DATA_W/8-1:0] core_byteen,
  input  logic              core_wren,
  input  logic              core_rden,
  output logic              core_ready,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic [AW-1:0]     disp_addr,
  input  logic              disp_rden,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              swap_req,
  input  logic              vsync_pulse,
  output logic              front_page,
  output logic              swap_pending,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_value,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int WORDS = NUM_PAGES * DEPTH;
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_next;
  logic [AW-1:0]       clear_cnt;
  logic [DATA_W-1:0]   clear_word;
  logic                back_page;
  logic                core_in_range, disp_in_range;
  logic                core_wr, core_rd;
  logic [DATA_W-1:0]   mem [WORDS];

  // Pages are laid out back to back; page 1 starts at word DEPTH.
  function automatic logic [IW-1:0] word_index(input logic page, input logic [AW-1:0] addr);
    return IW'(int'(page) * DEPTH + int'(addr));
  endfunction

  assign back_page     = (NUM_PAGES == 2) ? ~front_page : 1'b0;
  assign clear_busy    = (state == CLEAR);
  assign core_ready    = ~clear_busy;
  assign core_in_range = {1'b0, core_addr} < DEPTH_W;
  assign disp_in_range = {1'b0, disp_addr} < DEPTH_W;
  assign core_wr       = core_wren & core_ready & core_in_range;
  assign core_rd       = core_rden & core_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = CLEAR;
      CLEAR:   if (clear_cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clear_cnt  <= '0;
      clear_word <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      clear_done <= clear_busy && (clear_cnt == LAST);
      if (state == IDLE && clear_start) begin
        clear_cnt  <= '0;
        clear_word <= clear_value;
      end else if (clear_busy) begin
        clear_cnt <= clear_cnt + 1'b1;
      end
    end
  end

  // Storage is never reset; core writes cannot collide with the clear because ready is low.
  always_ff @(posedge clock) begin
    if (clear_busy) begin
      mem[word_index(back_page, clear_cnt)] <= clear_word;
    end else if (core_wr) begin
      for (int b = 0; b < BE_W; b++) begin
        if (core_byteen[b]) mem[word_index(back_page, core_addr)][b*8 +: 8] <= core_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      core_rdata  <= '0;
      core_rvalid <= 1'b0;
      disp_rdata  <= '0;
      disp_rvalid <= 1'b0;
    end else begin
      core_rvalid <= core_rd;
      disp_rvalid <= disp_rden;
      if (core_rd) core_rdata <= core_in_range ? mem[word_index(back_page, core_addr)] : '0;
      if (disp_rden) disp_rdata <= disp_in_range ? mem[word_index(front_page, disp_addr)] : '0;
    end
  end

  // A swap waits out any clear so the page being filled never becomes visible half-done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      front_page   <= 1'b0;
      swap_pending <= 1'b0;
    end else if (NUM_PAGES == 2) begin
      if (vsync_pulse && (swap_pending || swap_req) && !clear_busy) begin
        front_page   <= ~front_page;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_mem.sv
// Bench for vga_fb_mem: a double-buffer build (DEPTH=12) and a single-page build (DEPTH=16)
// share one stimulus stream and are compared every cycle against a word-array reference model.
module tb_vga_fb_mem;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [3:0]  core_byteen = '0;
  logic        core_wren = 1'b0, core_rden = 1'b0;
  logic [3:0]  disp_addr = '0;
  logic        disp_rden = 1'b0;
  logic        swap_req = 1'b0, vsync_pulse = 1'b0, clear_start = 1'b0;
  logic [31:0] clear_value = '0;

  logic        a_core_ready, a_core_rvalid, a_disp_rvalid, a_front_page, a_swap_pending, a_clear_busy, a_clear_done;
  logic [31:0] a_core_rdata, a_disp_rdata;
  logic        b_core_ready, b_core_rvalid, b_disp_rvalid, b_front_page, b_swap_pending, b_clear_busy, b_clear_done;
  logic [31:0] b_core_rdata, b_disp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  int          dep [2];
  int          npg [2];
  logic [31:0] mm [2][32];
  logic        fr [2], pend [2], done [2], crv [2], drv [2];
  logic [31:0] crd [2], drd [2], cval [2];
  int          cleft [2], cptr [2];

  vga_fb_mem #(.DATA_W(32), .DEPTH(12), .NUM_PAGES(2)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_byteen(core_byteen),
    .core_wren(core_wren), .core_rden(core_rden), .core_ready(a_core_ready),
    .core_rdata(a_core_rdata), .core_rvalid(a_core_rvalid),
    .disp_addr(disp_addr), .disp_rden(disp_rden), .disp_rdata(a_disp_rdata), .disp_rvalid(a_disp_rvalid),
    .swap_req(swap_req), .vsync_pulse(vsync_pulse), .front_page(a_front_page), .swap_pending(a_swap_pending),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(a_clear_busy), .clear_done(a_clear_done)
  );

  vga_fb_mem #(.DATA_W(32), .DEPTH(16), .NUM_PAGES(1)) dut_b (
    .clock(clock), .reset_n(reset_n),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_byteen(core_byteen),
    .core_wren(core_wren), .core_rden(core_rden), .core_ready(b_core_ready),
    .core_rdata(b_core_rdata), .core_rvalid(b_core_rvalid),
    .disp_addr(disp_addr), .disp_rden(disp_rden), .disp_rdata(b_disp_rdata), .disp_rvalid(b_disp_rvalid),
    .swap_req(swap_req), .vsync_pulse(vsync_pulse), .front_page(b_front_page), .swap_pending(b_swap_pending),
    .clear_start(clear_start), .clear_value(clear_value), .clear_busy(b_clear_busy), .clear_done(b_clear_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input string p, input logic ready, input logic [31:0] crdata,
                           input logic crvalid, input logic [31:0] drdata, input logic drvalid,
                           input logic front, input logic pending, input logic busy, input logic dn);
    checkOutput({p, "_core_ready"}, ready, !(cleft[k] > 0));
    checkOutput({p, "_clear_busy"}, busy, cleft[k] > 0);
    checkOutput({p, "_clear_done"}, dn, done[k]);
    checkOutput({p, "_core_rvalid"}, crvalid, crv[k]);
    checkOutput({p, "_core_rdata"}, crdata, crd[k]);
    checkOutput({p, "_disp_rvalid"}, drvalid, drv[k]);
    checkOutput({p, "_disp_rdata"}, drdata, drd[k]);
    checkOutput({p, "_front_page"}, front, fr[k]);
    checkOutput({p, "_swap_pending"}, pending, pend[k]);
  endtask

  task automatic check_both();
    check_dut(0, "dbl", a_core_ready, a_core_rdata, a_core_rvalid, a_disp_rdata, a_disp_rvalid,
              a_front_page, a_swap_pending, a_clear_busy, a_clear_done);
    check_dut(1, "sgl", b_core_ready, b_core_rdata, b_core_rvalid, b_disp_rdata, b_disp_rvalid,
              b_front_page, b_swap_pending, b_clear_busy, b_clear_done);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      fr[k] = 1'b0; pend[k] = 1'b0; done[k] = 1'b0; crv[k] = 1'b0; drv[k] = 1'b0;
      crd[k] = '0; drd[k] = '0; cleft[k] = 0; cptr[k] = 0;
    end
  endtask

  // Advance the model by one cycle using the currently driven inputs, clock the DUTs, compare.
  task automatic applyStimulus();
    for (int k = 0; k < 2; k++) begin
      bit busy;
      int back, ca, da;
      busy = cleft[k] > 0;
      back = (npg[k] == 2) ? int'(!fr[k]) : 0;
      ca = int'(core_addr);
      da = int'(disp_addr);
      crv[k] = core_rden && !busy;
      if (crv[k]) crd[k] = (ca < dep[k]) ? mm[k][back*dep[k] + ca] : 32'h0;
      drv[k] = disp_rden;
      if (disp_rden) drd[k] = (da < dep[k]) ? mm[k][int'(fr[k])*dep[k] + da] : 32'h0;
      if (core_wren && !busy && ca < dep[k]) begin
        for (int b = 0; b < 4; b++)
          if (core_byteen[b]) mm[k][back*dep[k] + ca][8*b +: 8] = core_wdata[8*b +: 8];
      end
      done[k] = 1'b0;
      if (busy) begin
        mm[k][back*dep[k] + cptr[k]] = cval[k];
        cptr[k]++;
        cleft[k]--;
        done[k] = (cleft[k] == 0);
      end else if (clear_start) begin
        cleft[k] = dep[k];
        cptr[k] = 0;
        cval[k] = clear_value;
      end
      if (npg[k] == 2) begin
        if (vsync_pulse && (pend[k] || swap_req) && !busy) begin
          fr[k] = !fr[k];
          pend[k] = 1'b0;
        end else if (swap_req) begin
          pend[k] = 1'b1;
        end
      end
    end
    @(posedge clock);
    #1;
    check_both();
  endtask

  task automatic clear_inputs();
    core_wren = 0; core_rden = 0; disp_rden = 0; swap_req = 0; vsync_pulse = 0; clear_start = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_both();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cleft[0] > 0 || cleft[1] > 0) && n < 40) begin
      applyStimulus();
      n++;
    end
    checkOutput("idle_budget", (cleft[0] > 0 || cleft[1] > 0), 0);
  endtask

  task automatic core_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    core_wren = 1; core_addr = a; core_wdata = d; core_byteen = be;
    applyStimulus();
    core_wren = 0;
  endtask

  task automatic core_read(input logic [3:0] a);
    core_rden = 1; core_addr = a;
    applyStimulus();
    core_rden = 0;
  endtask

  initial begin
    logic f0;
    dep[0] = 12; dep[1] = 16;
    npg[0] = 2;  npg[1] = 1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) mm[k][i] = '0;
    #2;
    do_reset();

    // Fill every page so that all later reads have known contents.
    clear_start = 1; clear_value = 32'h0BAD_F00D;
    applyStimulus();
    clear_start = 0;
    wait_idle();
    swap_req = 1; vsync_pulse = 1;
    applyStimulus();
    swap_req = 0; vsync_pulse = 0;
    checkOutput("imm_swap", a_front_page, 1);
    clear_start = 1; clear_value = 32'h1234_5678;
    applyStimulus();
    clear_start = 0;
    wait_idle();

    // Byte-enabled write over zero.
    core_write(4'd5, 32'h0, 4'hF);
    core_write(4'd5, 32'hAABB_CCDD, 4'b0101);
    core_read(4'd5);
    checkOutput("be_rvalid", a_core_rvalid, 1);
    checkOutput("be_rdata", a_core_rdata, 32'h00BB_00DD);
    applyStimulus();
    checkOutput("be_rvalid_drop", a_core_rvalid, 0);

    // Write the back page, swap on vsync, read it back through the display port.
    core_write(4'd0, 32'h11, 4'hF);
    swap_req = 1; applyStimulus(); swap_req = 0;
    vsync_pulse = 1; applyStimulus(); vsync_pulse = 0;
    checkOutput("dbuf_pending", a_swap_pending, 0);
    disp_rden = 1; disp_addr = 4'd0; applyStimulus(); disp_rden = 0;
    checkOutput("dbuf_disp", a_disp_rdata, 32'h11);

    // Armed swap waits for vsync.
    f0 = fr[0];
    swap_req = 1; applyStimulus(); swap_req = 0;
    repeat (29) begin
      applyStimulus();
      checkOutput("pend_hold", a_swap_pending, 1);
    end
    vsync_pulse = 1; applyStimulus(); vsync_pulse = 0;
    checkOutput("pend_swap", a_front_page, !f0);

    // Clear with a vsync in the middle: no swap until after the clear.
    f0 = fr[0];
    clear_start = 1; clear_value = 32'hDEAD_BEEF; swap_req = 1;
    applyStimulus();
    clear_start = 0; swap_req = 0;
    repeat (4) applyStimulus();
    vsync_pulse = 1; applyStimulus(); vsync_pulse = 0;
    checkOutput("midclr_noswap", a_front_page, f0);
    checkOutput("midclr_pending", a_swap_pending, 1);
    wait_idle();
    for (int a = 0; a < 12; a++) begin
      core_read(4'(a));
      checkOutput("clr_word", a_core_rdata, 32'hDEAD_BEEF);
    end
    vsync_pulse = 1; applyStimulus(); vsync_pulse = 0;
    checkOutput("postclr_swap", a_front_page, !f0);

    // Out-of-range accesses and same-cycle write/read.
    core_write(4'd12, 32'hCAFE_CAFE, 4'hF);
    core_read(4'd12);
    checkOutput("oor_rvalid", a_core_rvalid, 1);
    checkOutput("oor_rdata", a_core_rdata, 32'h0);
    disp_rden = 1; disp_addr = 4'd15; applyStimulus(); disp_rden = 0;
    checkOutput("oor_disp", a_disp_rdata, 32'h0);
    core_write(4'd3, 32'h3333_3333, 4'hF);
    core_wren = 1; core_rden = 1; core_addr = 4'd3; core_wdata = 32'h4444_4444; core_byteen = 4'hF;
    applyStimulus();
    core_wren = 0; core_rden = 0;
    checkOutput("rw_same_old", a_core_rdata, 32'h3333_3333);
    core_read(4'd3);

    // Reset in the middle of a clear, then a clean clear.
    clear_start = 1; clear_value = $urandom;
    applyStimulus();
    clear_start = 0;
    repeat (7) applyStimulus();
    do_reset();
    checkOutput("rst_busy", a_clear_busy, 0);
    applyStimulus();
    checkOutput("rst_no_done", a_clear_done, 0);
    clear_start = 1; clear_value = $urandom;
    applyStimulus();
    clear_start = 0;
    wait_idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      core_addr   = 4'($urandom_range(0, 15));
      core_wdata  = $urandom;
      core_byteen = 4'($urandom_range(0, 15));
      core_wren   = ($urandom_range(0, 2) == 0);
      core_rden   = ($urandom_range(0, 2) == 0);
      disp_addr   = 4'($urandom_range(0, 15));
      disp_rden   = ($urandom_range(0, 2) == 0);
      swap_req    = ($urandom_range(0, 19) == 0);
      vsync_pulse = ($urandom_range(0, 29) == 0);
      clear_start = ($urandom_range(0, 99) == 0);
      clear_value = $urandom;
      applyStimulus();
    end
    clear_inputs();
    checkOutput("single_front", b_front_page, 0);
    checkOutput("single_pending", b_swap_pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_mem.md
# vga_fb_mem

Parametrised, double-buffered VGA frame-buffer memory for the LOTR tile. It is the successor of the fixed 80x480 single-page VGA memory. The core writes and reads the back page through a byte-enabled port. The VGA controller streams the front page through a read-only port. Pages swap only at vertical sync, and a hardware clear engine fills the back page without core involvement. Single clock domain.

## Interface
- DATA_W, 32: word width in bits; multiple of 8.
- DEPTH, 9600: words per page (80 bytes x 480 lines / 4).
- NUM_PAGES, 2: 1 (single buffer) or 2 (double buffer); other values are illegal.
- AW, $clog2(DEPTH): word-address width of both ports (derived).
- clock  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- core_addr  in  AW  word index within the back page.
- core_wdata  in  DATA_W  write data.
- core_byteen  in  DATA_W/8  byte enables for writes.
- core_wren  in  1  write request.
- core_rden  in  1  read request.
- core_ready  out  1  core port accepts requests; low while clearing.
- core_rdata  out  DATA_W  read data.
- core_rvalid  out  1  core_rdata valid.
- disp_addr  in  AW  word index within the front page.
- disp_rden  in  1  display read request.
- disp_rdata  out  DATA_W  display read data.
- disp_rvalid  out  1  disp_rdata valid.
- swap_req  in  1  request a page swap at the next vsync.
- vsync_pulse  in  1  one-cycle frame-boundary strobe from the VGA controller.
- front_page  out  1  index of the page currently displayed.
- swap_pending  out  1  a swap is armed and waiting for vsync.
- clear_start  in  1  start filling the back page.
- clear_value  in  DATA_W  fill word.
- clear_busy  out  1  clear engine active.
- clear_done  out  1  one-cycle pulse when the clear completes.

## Operation
- Storage is NUM_PAGES x DEPTH words. The back page is ~front_page when NUM_PAGES=2, and page 0 when NUM_PAGES=1.
- Display port reads the front page. With NUM_PAGES=1 it reads the same page the core writes.
- Core write: applied when core_wren && core_ready && core_addr < DEPTH. Only bytes with core_byteen set are written.
- Core read: accepted when core_rden && core_ready.
- Out-of-range core address (>= DEPTH): the write is dropped. A read returns 0 with core_rvalid=1.
- Out-of-range disp_addr: returns 0 with disp_rvalid=1.
- Same-cycle core write and core read of one word: the read returns the old data.
- Display read of a word the core writes in the same cycle: returns old data. This case cannot occur with NUM_PAGES=2 and no swap in that cycle.
- Swap logic:
  - swap_req sets swap_pending.
  - On vsync_pulse with (swap_pending || swap_req) && !clear_busy, front_page toggles and swap_pending clears.
  - With NUM_PAGES=1, swap_req is ignored: front_page and swap_pending stay 0.
- Clear FSM: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_start; clear_value is latched and the word counter is set to 0.
  - In CLEAR, one full word is written to the back page per cycle, at counter address. The counter increments each cycle.
  - CLEAR -> IDLE after writing word DEPTH-1; clear_done pulses in the cycle after that last write.
  - clear_start while busy is ignored.
- core_ready = !clear_busy. Core requests while not ready are dropped: no write, no rvalid.
- The display port is unaffected by clears.
- A vsync during a clear does not swap; swap_pending holds until the first vsync after clear_busy falls.
- Reset clears all control state. Memory contents are not reset. Reset during a clear aborts it: the back page is partially filled, no clear_done.

## Timing
- Read latency on both ports is 1 cycle: request in cycle N gives rdata and rvalid registered at the edge ending N.
- rvalid is high for exactly one cycle per accepted request.
- rdata holds its last value while rvalid=0.
- Writes are visible to reads issued in the next cycle.
- front_page changes at the clock edge ending the vsync_pulse cycle. Display reads issued in the following cycle use the new page.
- A clear takes exactly DEPTH cycles in CLEAR. clear_busy rises the cycle after clear_start and falls with the clear_done pulse.
- Reset values: core_rdata=0, core_rvalid=0, disp_rdata=0, disp_rvalid=0, front_page=0, swap_pending=0, clear_busy=0, clear_done=0, core_ready=1.

## Test plan
- Byte-enable write: write 0xAABBCCDD to addr 5 with byteen 4'b0101, after a prior 0x0 → read of addr 5 returns 0x00BB00DD, with rvalid one cycle after rden.
- Double buffer: core writes 0x11 to addr 0 of back page (page 1); swap_req; vsync_pulse → front_page=1, swap_pending=0, display read of addr 0 returns 0x11.
- Pending swap:
  - swap_req at cycle 10, vsync at cycle 40 → swap_pending is high for cycles 11-40 and front_page toggles after cycle 40.
  - swap_req and vsync in the same cycle → immediate swap.
- Clear with DEPTH=16:
  - clear_start with clear_value 0xDEADBEEF → clear_busy high for 16 cycles, core_ready=0, clear_done pulses once; every back-page word reads 0xDEADBEEF; front-page data is unchanged.
  - A vsync mid-clear → no swap until the next vsync.
- Boundaries:
  - Write to addr DEPTH → dropped.
  - Read of addr DEPTH → 0 with rvalid.
  - Same-cycle write and read of addr 3 → old data.
  - NUM_PAGES=1 build → swap_req has no effect.
- Reset mid-clear: assert reset_n=0 at clear word 7 → all outputs at reset values immediately, FSM in IDLE, no clear_done; a new clear_start after release completes normally.
